// File: rtl/debug_dump_tx.sv
// Debug snapshot readout: SYNC, LEN, data bytes (word 0 first, MSB first), XOR checksum.
// Optional DBG_DUMP_TIMESTAMP_EN appends a captured 32-bit cycle count to each frame.
module debug_dump_tx #(
  parameter int          NUM_WORDS = 3,
  parameter int          WORD_W    = 32,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        trig_i,
  input  logic [NUM_WORDS*WORD_W-1:0] dbg_words_i,
  output logic [7:0]                  tx_data_o,
  output logic                        tx_vld_o,
  input  logic                        tx_rdy_i,
  output logic                        busy_o,
  output logic                        frame_done_o,
  output logic [7:0]                  drop_cnt_o
);

  localparam int BPW = WORD_W / 8;
  localparam int WB  = NUM_WORDS * BPW;
`ifdef DBG_DUMP_TIMESTAMP_EN
  localparam int NB  = WB + 4;
`else
  localparam int NB  = WB;
`endif
  localparam logic [7:0] LEN  = 8'(NB);
  localparam logic [7:0] LAST = 8'(NB - 1);

  if (NB > 255) begin : g_len_chk
    $error("debug_dump_tx: frame length exceeds 255 bytes");
  end
  if (WORD_W % 8 != 0) begin : g_w_chk
    $error("debug_dump_tx: WORD_W must be a multiple of 8");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_LEN,
    S_DATA,
    S_CSUM
  } state_t;

  state_t          state;
  logic            vld;
  logic [7:0]      idx;
  logic [7:0]      nidx;
  logic [7:0]      csum;
  logic [NB*8-1:0] snap;
  logic [NB*8-1:0] cap;
  logic            xfer;

`ifdef DBG_DUMP_TIMESTAMP_EN
  logic [31:0] ts;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts <= '0;
    else     ts <= ts + 32'd1;
  end
`endif

  // Snapshot is stored in transmit order, byte 0 in the LSBs.
  always_comb begin
    cap = '0;
    for (int w = 0; w < NUM_WORDS; w++) begin
      for (int b = 0; b < BPW; b++) begin
        cap[(w*BPW+b)*8 +: 8] =
          dbg_words_i[w*WORD_W + (BPW-1-b)*8 +: 8];
      end
    end
`ifdef DBG_DUMP_TIMESTAMP_EN
    for (int b = 0; b < 4; b++) begin
      cap[(WB+b)*8 +: 8] = ts[(3-b)*8 +: 8];
    end
`endif
  end

  assign xfer     = vld & tx_rdy_i;
  assign nidx     = idx + 8'd1;
  assign tx_vld_o = vld;
  assign busy_o   = vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      vld          <= 1'b0;
      tx_data_o    <= '0;
      frame_done_o <= 1'b0;
      drop_cnt_o   <= '0;
      idx          <= '0;
      csum         <= '0;
      snap         <= '0;
    end else begin
      frame_done_o <= 1'b0;
      if (state != S_IDLE && trig_i && drop_cnt_o != 8'hFF)
        drop_cnt_o <= drop_cnt_o + 8'd1;
      unique case (state)
        S_IDLE: begin
          if (trig_i) begin
            snap      <= cap;
            csum      <= '0;
            idx       <= '0;
            tx_data_o <= SYNC_BYTE;
            vld       <= 1'b1;
            state     <= S_SYNC;
          end
        end
        S_SYNC: begin
          if (xfer) begin
            tx_data_o <= LEN;
            state     <= S_LEN;
          end
        end
        S_LEN: begin
          if (xfer) begin
            csum      <= csum ^ tx_data_o;
            tx_data_o <= snap[7:0];
            idx       <= '0;
            state     <= S_DATA;
          end
        end
        S_DATA: begin
          if (xfer) begin
            csum <= csum ^ tx_data_o;
            if (idx == LAST) begin
              tx_data_o <= csum ^ tx_data_o;
              state     <= S_CSUM;
            end else begin
              idx       <= nidx;
              tx_data_o <= snap[8*nidx +: 8];
            end
          end
        end
        S_CSUM: begin
          if (xfer) begin
            vld          <= 1'b0;
            frame_done_o <= 1'b1;
            tx_data_o    <= '0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
